maxpool2x2_stream: RTL and testbench



---
 rtl/maxpool2x2_stream.sv | 176 +++++++++++++++++
 tb/tb_maxpool2x2_stream.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool2x2_stream.sv
// maxpool2x2_stream: streaming 2x2 / stride-2 signed max-pool stage.
// It accepts raster-ordered samples over a ready/valid handshake. Each
// horizontal pair is reduced to its maximum. On even rows, that pair-maximum
// is stored in a half-row buffer. On odd rows, it is combined with the
// buffered value to produce one pooled sample per 2x2 block.
//
// Ports:
//   clk_i, rst_ni     clock, synchronous active-low reset
//   start_i           single-cycle pulse: clear counters/output, begin new frame
//   in_data_i         signed input sample          (in_valid_i / in_ready_o)
//   out_data_o        signed pooled sample         (out_valid_o / out_ready_i)
//   busy_o            frame in progress
//   frame_done_o      one-cycle pulse after the last sample of a frame
//   out_last_o        (only with MAXPOOL_OUT_LAST_EN) marks the final pooled
//                     sample of a frame
//
// Optional feature macro: MAXPOOL_OUT_LAST_EN
module maxpool2x2_stream #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned IMG_WIDTH  = 26,
  parameter int unsigned IMG_HEIGHT = 26
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         start_i,
  input  logic signed [DATA_WIDTH-1:0] in_data_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  output logic signed [DATA_WIDTH-1:0] out_data_o,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic                         busy_o,
  output logic                         frame_done_o
`ifdef MAXPOOL_OUT_LAST_EN
  ,
  output logic                         out_last_o
`endif
);

  localparam int unsigned HALF_W = IMG_WIDTH / 2;
  localparam int unsigned COL_W  = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int unsigned ROW_W  = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int unsigned BUF_AW = (HALF_W > 1) ? $clog2(HALF_W) : 1;

  logic [COL_W-1:0]              col_q, col_d;
  logic [ROW_W-1:0]              row_q, row_d;
  logic signed [DATA_WIDTH-1:0]  pair_q, pair_d;
  logic signed [DATA_WIDTH-1:0]  rowbuf_q [HALF_W];
  logic signed [DATA_WIDTH-1:0]  rowbuf_d [HALF_W];
  logic signed [DATA_WIDTH-1:0]  out_data_q, out_data_d;
  logic                          out_valid_q, out_valid_d;
  logic                          busy_q, busy_d;
  logic                          frame_done_q, frame_done_d;
`ifdef MAXPOOL_OUT_LAST_EN
  logic                          last_q, last_d;
`endif

  logic                          beat;
  logic                          col_last, row_last;
  logic [BUF_AW-1:0]             buf_idx;
  logic signed [DATA_WIDTH-1:0]  pm, pool;

  // Input is blocked by start and by an output that is held but not consumed.
  assign in_ready_o = !start_i && !(out_valid_q && !out_ready_i);
  assign beat       = in_valid_i && in_ready_o;

  assign col_last = (col_q == COL_W'(IMG_WIDTH - 1));
  assign row_last = (row_q == ROW_W'(IMG_HEIGHT - 1));
  assign buf_idx  = BUF_AW'(col_q >> 1);

  // Pair maximum, and block maximum against the pair stored one row up.
  assign pm   = (in_data_i > pair_q) ? in_data_i : pair_q;
  assign pool = (pm > rowbuf_q[buf_idx]) ? pm : rowbuf_q[buf_idx];

  // Next-state logic: raster counters, row buffer, output register.
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    pair_d       = pair_q;
    rowbuf_d     = rowbuf_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
`ifdef MAXPOOL_OUT_LAST_EN
    last_d       = last_q;
`endif

    if (out_valid_q && out_ready_i) begin
      out_valid_d = 1'b0;
`ifdef MAXPOOL_OUT_LAST_EN
      last_d      = 1'b0;
`endif
    end

    if (start_i) begin
      col_d       = '0;
      row_d       = '0;
      out_data_d  = '0;
      out_valid_d = 1'b0;
      busy_d      = 1'b0;
`ifdef MAXPOOL_OUT_LAST_EN
      last_d      = 1'b0;
`endif
    end else if (beat) begin
      busy_d = 1'b1;
      if (col_last) begin
        col_d = '0;
        if (row_last) begin
          row_d        = '0;
          busy_d       = 1'b0;
          frame_done_d = 1'b1;
        end else begin
          row_d = row_q + ROW_W'(1);
        end
      end else begin
        col_d = col_q + COL_W'(1);
      end

      // An odd trailing column/row lands on the even paths and is never used.
      if (!col_q[0]) begin
        pair_d = in_data_i;
      end else if (!row_q[0]) begin
        rowbuf_d[buf_idx] = pm;
      end else begin
        out_data_d  = pool;
        out_valid_d = 1'b1;
`ifdef MAXPOOL_OUT_LAST_EN
        last_d = ((row_q >> 1) == ROW_W'(IMG_HEIGHT / 2 - 1)) &&
                 ((col_q >> 1) == COL_W'(HALF_W - 1));
`endif
      end
    end
  end

  // Control and output state.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      col_q        <= '0;
      row_q        <= '0;
      pair_q       <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef MAXPOOL_OUT_LAST_EN
      last_q       <= 1'b0;
`endif
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      pair_q       <= pair_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
`ifdef MAXPOOL_OUT_LAST_EN
      last_q       <= last_d;
`endif
    end
  end

  // The row buffer needs no reset; each entry is written before it is read.
  always_ff @(posedge clk_i) begin
    rowbuf_q <= rowbuf_d;
  end

  assign out_data_o   = out_data_q;
  assign out_valid_o  = out_valid_q;
  assign busy_o       = busy_q;
  assign frame_done_o = frame_done_q;
`ifdef MAXPOOL_OUT_LAST_EN
  assign out_last_o   = last_q;
`endif

endmodule

// File: tb/tb_maxpool2x2_stream.sv
module tb_maxpool2x2_stream;

  localparam int unsigned DW = 32;
  typedef logic signed [DW-1:0] smp_t;
  typedef smp_t q_t[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // 4x4 instance
  logic rst_n = 1'b0;
  logic start = 1'b0;
  smp_t in_data = '0;
  logic in_valid = 1'b0;
  logic in_ready;
  smp_t out_data;
  logic out_valid;
  logic out_ready = 1'b1;
  logic busy, frame_done;
`ifdef MAXPOOL_OUT_LAST_EN
  logic out_last;
`endif

  // 5x5 instance
  logic d5_start = 1'b0;
  smp_t d5_in_data = '0;
  logic d5_in_valid = 1'b0;
  logic d5_in_ready;
  smp_t d5_out_data;
  logic d5_out_valid;
  logic d5_out_ready = 1'b1;
  logic d5_busy, d5_frame_done;
`ifdef MAXPOOL_OUT_LAST_EN
  logic d5_out_last;
`endif

  maxpool2x2_stream #(.DATA_WIDTH(DW), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start),
    .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .out_data_o(out_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .busy_o(busy), .frame_done_o(frame_done)
`ifdef MAXPOOL_OUT_LAST_EN
    , .out_last_o(out_last)
`endif
  );

  maxpool2x2_stream #(.DATA_WIDTH(DW), .IMG_WIDTH(5), .IMG_HEIGHT(5)) dut5 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(d5_start),
    .in_data_i(d5_in_data), .in_valid_i(d5_in_valid), .in_ready_o(d5_in_ready),
    .out_data_o(d5_out_data), .out_valid_o(d5_out_valid), .out_ready_i(d5_out_ready),
    .busy_o(d5_busy), .frame_done_o(d5_frame_done)
`ifdef MAXPOOL_OUT_LAST_EN
    , .out_last_o(d5_out_last)
`endif
  );

  // 0: always ready, 1: random, 2: held low
  int ready_mode = 0;
  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // Output collection, sampled mid-cycle
  q_t got_q;
  q_t got5_q;
  logic got_last_q[$];
  int fd_cnt = 0;
  int fd5_cnt = 0;
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      got_q.push_back(out_data);
`ifdef MAXPOOL_OUT_LAST_EN
      got_last_q.push_back(out_last);
`else
      got_last_q.push_back(1'b0);
`endif
    end
    if (d5_out_valid && d5_out_ready) got5_q.push_back(d5_out_data);
    if (frame_done) fd_cnt++;
    if (d5_frame_done) fd5_cnt++;
  end

  // Reference: max over each complete 2x2 block, raster order, floor geometry
  function automatic q_t pool_ref(input int w, input int h, input q_t s);
    q_t r;
    for (int br = 0; br < h / 2; br++)
      for (int bc = 0; bc < w / 2; bc++) begin
        smp_t m = s[2*br*w + 2*bc];
        if (s[2*br*w + 2*bc + 1] > m) m = s[2*br*w + 2*bc + 1];
        if (s[(2*br+1)*w + 2*bc] > m) m = s[(2*br+1)*w + 2*bc];
        if (s[(2*br+1)*w + 2*bc + 1] > m) m = s[(2*br+1)*w + 2*bc + 1];
        r.push_back(m);
      end
    return r;
  endfunction

  task automatic send(input smp_t v);
    bit acc = 1'b0;
    in_data  = v;
    in_valid = 1'b1;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++; failures++;
      $display("FAIL send_timeout: sample %0d not accepted, in_ready=%b", v, in_ready);
    end
  endtask

  task automatic send_frame(input q_t s, input bit gaps);
    foreach (s[i]) begin
      send(s[i]);
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < 200 && got_q.size() < n; k++) begin @(posedge clk); #1; end
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || busy !== 1'b0 || frame_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: valid=%b data=%0d busy=%b done=%b, want 0 0 0 0",
               out_valid, out_data, busy, frame_done);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    q_t exp = '{5, 7, 13, 15};
    int fd0 = fd_cnt;
    got_q.delete(); got_last_q.delete();
    for (int i = 0; i < 16; i++) begin
      send(smp_t'(i));
      if (i == 0) begin
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_mid: got %b want 1", busy); end
      end
      if (i == 5) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== smp_t'(5)) begin
          failures++;
          $display("FAIL basic_latency: valid=%b data=%0d want 1 5", out_valid, out_data);
        end
      end
      if (i == 15) begin
        checks++;
        if (frame_done !== 1'b1 || busy !== 1'b0) begin
          failures++;
          $display("FAIL basic_frame_end: done=%b busy=%b want 1 0", frame_done, busy);
        end
      end
    end
    @(posedge clk); #1;
    checks++;
    if (frame_done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse: got %b want 0", frame_done); end
    drain(4);
    checks++;
    if (got_q.size() != 4) begin failures++; $display("FAIL basic_count: got %0d want 4", got_q.size()); end
    foreach (exp[i]) begin
      smp_t g = (i < got_q.size()) ? got_q[i] : 'x;
      checks++;
      if (g !== exp[i]) begin failures++; $display("FAIL basic_out[%0d]: got %0d want %0d", i, g, exp[i]); end
    end
    checks++;
    if (fd_cnt - fd0 != 1) begin failures++; $display("FAIL basic_done_count: got %0d want 1", fd_cnt - fd0); end
`ifdef MAXPOOL_OUT_LAST_EN
    foreach (exp[i]) begin
      logic gl = (i < got_last_q.size()) ? got_last_q[i] : 1'bx;
      checks++;
      if (gl !== (i == 3)) begin failures++; $display("FAIL basic_last[%0d]: got %b want %b", i, gl, i == 3); end
    end
`endif
  endtask

  task automatic test_signed();
    q_t exp = '{-11, -9, -3, -1};
    q_t s;
    got_q.delete(); got_last_q.delete();
    for (int i = 0; i < 16; i++) s.push_back(smp_t'(i - 16));
    send_frame(s, 1'b0);
    drain(4);
    foreach (exp[i]) begin
      smp_t g = (i < got_q.size()) ? got_q[i] : 'x;
      checks++;
      if (g !== exp[i]) begin failures++; $display("FAIL signed_neg[%0d]: got %0d want %0d", i, g, exp[i]); end
    end
    s.delete(); got_q.delete(); got_last_q.delete();
    s = '{32'sh80000000, 32'sh7FFFFFFF, 32'sh80000000, 32'sh80000001,
          32'sh80000000, 32'sh80000000, 32'sh80000000, -1,
          32'sh7FFFFFFF, 0, -5, -7,
          32'sh80000000, 32'sh7FFFFFFE, -9, -6};
    send_frame(s, 1'b0);
    drain(4);
    begin
      smp_t g = (got_q.size() > 0) ? got_q[0] : 'x;
      checks++;
      if (g !== 32'sh7FFFFFFF) begin failures++; $display("FAIL signed_extreme: got %0h want 7fffffff", g); end
    end
    exp = pool_ref(4, 4, s);
    foreach (exp[i]) begin
      smp_t g = (i < got_q.size()) ? got_q[i] : 'x;
      checks++;
      if (g !== exp[i]) begin failures++; $display("FAIL signed_ext[%0d]: got %0d want %0d", i, g, exp[i]); end
    end
  endtask

  task automatic test_stall();
    q_t exp = '{5, 7, 13, 15};
    got_q.delete(); got_last_q.delete();
    for (int i = 0; i < 4; i++) send(smp_t'(i));
    ready_mode = 2;
    send(smp_t'(4));
    send(smp_t'(5));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== smp_t'(5) || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold[%0d]: valid=%b data=%0d in_ready=%b want 1 5 0",
                 k, out_valid, out_data, in_ready);
      end
    end
    checks++;
    if (got_q.size() != 0) begin failures++; $display("FAIL stall_early: got %0d outputs want 0", got_q.size()); end
    ready_mode = 0;
    for (int i = 6; i < 16; i++) send(smp_t'(i));
    drain(4);
    checks++;
    if (got_q.size() != 4) begin failures++; $display("FAIL stall_count: got %0d want 4", got_q.size()); end
    foreach (exp[i]) begin
      smp_t g = (i < got_q.size()) ? got_q[i] : 'x;
      checks++;
      if (g !== exp[i]) begin failures++; $display("FAIL stall_out[%0d]: got %0d want %0d", i, g, exp[i]); end
    end
  endtask

  task automatic test_odd_geometry();
    q_t exp = '{6, 8, 16, 18};
    int fd0 = fd5_cnt;
    got5_q.delete();
    for (int i = 0; i < 25; i++) begin
      bit acc = 1'b0;
      d5_in_data  = smp_t'(i);
      d5_in_valid = 1'b1;
      for (int n = 0; n < 200 && !acc; n++) begin
        @(negedge clk); acc = d5_in_ready; @(posedge clk); #1;
      end
      d5_in_valid = 1'b0;
      if (!acc) begin checks++; failures++; $display("FAIL odd_send_timeout: sample %0d", i); end
      if (i == 24) begin
        checks++;
        if (d5_frame_done !== 1'b1 || d5_busy !== 1'b0) begin
          failures++;
          $display("FAIL odd_frame_end: done=%b busy=%b want 1 0", d5_frame_done, d5_busy);
        end
      end
    end
    repeat (4) begin @(posedge clk); #1; end
    checks++;
    if (got5_q.size() != 4) begin failures++; $display("FAIL odd_count: got %0d want 4", got5_q.size()); end
    foreach (exp[i]) begin
      smp_t g = (i < got5_q.size()) ? got5_q[i] : 'x;
      checks++;
      if (g !== exp[i]) begin failures++; $display("FAIL odd_out[%0d]: got %0d want %0d", i, g, exp[i]); end
    end
    checks++;
    if (fd5_cnt - fd0 != 1) begin failures++; $display("FAIL odd_done_count: got %0d want 1", fd5_cnt - fd0); end
  endtask

  task automatic test_start_abort();
    q_t exp = '{5, 7, 13, 15};
    int fd0;
    got_q.delete(); got_last_q.delete();
    ready_mode = 2;
    for (int i = 0; i < 6; i++) send(smp_t'(i));
    checks++;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL abort_pending: got %b want 1", out_valid); end
    fd0 = fd_cnt;
    in_data = smp_t'(1000); in_valid = 1'b1; start = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL abort_in_ready: got %b want 0", in_ready); end
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL abort_clear: valid=%b busy=%b want 0 0", out_valid, busy);
    end
    ready_mode = 0;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (got_q.size() != 0 || fd_cnt != fd0) begin
      failures++; $display("FAIL abort_dropped: outputs=%0d done=%0d want 0 0", got_q.size(), fd_cnt - fd0);
    end
    for (int i = 0; i < 16; i++) send(smp_t'(i));
    drain(4);
    foreach (exp[i]) begin
      smp_t g = (i < got_q.size()) ? got_q[i] : 'x;
      checks++;
      if (g !== exp[i]) begin failures++; $display("FAIL abort_out[%0d]: got %0d want %0d", i, g, exp[i]); end
    end
  endtask

  task automatic test_reset_midframe();
    q_t exp = '{105, 107, 113, 115};
    got_q.delete(); got_last_q.delete();
    for (int i = 0; i < 9; i++) send(smp_t'(i));
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || busy !== 1'b0 || frame_done !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_state: valid=%b data=%0d busy=%b done=%b want 0 0 0 0",
               out_valid, out_data, busy, frame_done);
    end
    rst_n = 1'b1;
    got_q.delete(); got_last_q.delete();
    for (int i = 100; i < 116; i++) send(smp_t'(i));
    drain(4);
    checks++;
    if (got_q.size() != 4) begin failures++; $display("FAIL rst_mid_count: got %0d want 4", got_q.size()); end
    foreach (exp[i]) begin
      smp_t g = (i < got_q.size()) ? got_q[i] : 'x;
      checks++;
      if (g !== exp[i]) begin failures++; $display("FAIL rst_mid_out[%0d]: got %0d want %0d", i, g, exp[i]); end
    end
`ifdef MAXPOOL_OUT_LAST_EN
    foreach (exp[i]) begin
      logic gl = (i < got_last_q.size()) ? got_last_q[i] : 1'bx;
      checks++;
      if (gl !== (i == 3)) begin failures++; $display("FAIL rst_mid_last[%0d]: got %b want %b", i, gl, i == 3); end
    end
`endif
  endtask

  task automatic test_random();
    int fd0 = fd_cnt;
    ready_mode = 1;
    for (int f = 0; f < 3; f++) begin
      q_t s;
      q_t exp;
      got_q.delete(); got_last_q.delete();
      for (int i = 0; i < 16; i++) s.push_back(smp_t'($urandom));
      exp = pool_ref(4, 4, s);
      send_frame(s, 1'b1);
      drain(4);
      checks++;
      if (got_q.size() != 4) begin failures++; $display("FAIL rand_count[f%0d]: got %0d want 4", f, got_q.size()); end
      foreach (exp[i]) begin
        smp_t g = (i < got_q.size()) ? got_q[i] : 'x;
        checks++;
        if (g !== exp[i]) begin failures++; $display("FAIL rand_out[f%0d][%0d]: got %0d want %0d", f, i, g, exp[i]); end
      end
    end
    ready_mode = 0;
    checks++;
    if (fd_cnt - fd0 != 3) begin failures++; $display("FAIL rand_done_count: got %0d want 3", fd_cnt - fd0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_stall();
    test_odd_geometry();
    test_start_abort();
    test_reset_midframe();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
